// File: rtl/latent_buffer_loader.sv
// Run-time loader for one PE's mu/var window: consumes a mu stream then a var
// stream, captures the 64-word window into two 8x8 banks, serves 8-lane column reads.
module latent_buffer_loader #(
    parameter int ADDR_BASE  = 0,
    parameter int STREAM_LEN = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    output logic        load_done,
    input  logic        rd_en,
    input  logic        rd_sel,
    input  logic [2:0]  rd_col,
    output logic        rd_valid,
    output logic [15:0] rd_data_1,
    output logic [15:0] rd_data_2,
    output logic [15:0] rd_data_3,
    output logic [15:0] rd_data_4,
    output logic [15:0] rd_data_5,
    output logic [15:0] rd_data_6,
    output logic [15:0] rd_data_7,
    output logic [15:0] rd_data_8
);

    localparam int CW     = $clog2(STREAM_LEN);
    localparam int LAST_I = STREAM_LEN - 1;
    localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];
    localparam logic [CW:0]   BASE = ADDR_BASE[CW:0];

    typedef enum logic [1:0] {IDLE, LOAD_MU, LOAD_VAR, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   word_cnt;
    logic [15:0]     mu_bank  [8][8];
    logic [15:0]     var_bank [8][8];
    logic [15:0]     rd_lane  [8];
    logic            handshake;
    logic [CW:0]     offset;
    logic            in_window;

    assign handshake = wr_valid & wr_ready;
    // Words below the window wrap to a large offset, so one range test covers both edges.
    assign offset    = {1'b0, word_cnt} - BASE;
    assign in_window = (offset[CW:6] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            word_cnt  <= '0;
            wr_ready  <= 1'b0;
            load_done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= LOAD_MU;
                        word_cnt  <= '0;
                        wr_ready  <= 1'b1;
                        load_done <= 1'b0;
                    end
                end
                LOAD_MU: begin
                    if (handshake) begin
                        if (word_cnt == LAST) begin
                            state    <= LOAD_VAR;
                            word_cnt <= '0;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                LOAD_VAR: begin
                    if (handshake) begin
                        if (word_cnt == LAST) begin
                            state     <= DONE;
                            word_cnt  <= '0;
                            wr_ready  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bank storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!rst && handshake && in_window) begin
            if (state == LOAD_MU)
                mu_bank[offset[5:3]][offset[2:0]] <= wr_data;
            else if (state == LOAD_VAR)
                var_bank[offset[5:3]][offset[2:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            for (int k = 0; k < 8; k++)
                rd_lane[k] <= '0;
        end else begin
            rd_valid <= rd_en && (state == DONE);
            if (rd_en) begin
                for (int k = 0; k < 8; k++)
                    rd_lane[k] <= (state != DONE) ? 16'h0000 :
                                  (rd_sel ? var_bank[k][rd_col] : mu_bank[k][rd_col]);
            end
        end
    end

    assign rd_data_1 = rd_lane[0];
    assign rd_data_2 = rd_lane[1];
    assign rd_data_3 = rd_lane[2];
    assign rd_data_4 = rd_lane[3];
    assign rd_data_5 = rd_lane[4];
    assign rd_data_6 = rd_lane[5];
    assign rd_data_7 = rd_lane[6];
    assign rd_data_8 = rd_lane[7];

endmodule

// File: tb/tb_latent_buffer_loader.sv
// Directed bench for latent_buffer_loader: two instances (ADDR_BASE 64 and 0) share one stimulus.
module tb_latent_buffer_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        rd_en;
    logic        rd_sel;
    logic [2:0]  rd_col;

    logic        ready64, done64, valid64;
    logic        ready0, done0, valid0;
    logic [15:0] l64 [8];
    logic [15:0] l0  [8];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    latent_buffer_loader #(.ADDR_BASE(64), .STREAM_LEN(1024)) dut64 (
        .clk(clk), .rst(rst), .start(start), .wr_valid(wr_valid), .wr_ready(ready64),
        .wr_data(wr_data), .load_done(done64), .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_col(rd_col), .rd_valid(valid64),
        .rd_data_1(l64[0]), .rd_data_2(l64[1]), .rd_data_3(l64[2]), .rd_data_4(l64[3]),
        .rd_data_5(l64[4]), .rd_data_6(l64[5]), .rd_data_7(l64[6]), .rd_data_8(l64[7])
    );

    latent_buffer_loader #(.ADDR_BASE(0), .STREAM_LEN(1024)) dut0 (
        .clk(clk), .rst(rst), .start(start), .wr_valid(wr_valid), .wr_ready(ready0),
        .wr_data(wr_data), .load_done(done0), .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_col(rd_col), .rd_valid(valid0),
        .rd_data_1(l0[0]), .rd_data_2(l0[1]), .rd_data_3(l0[2]), .rd_data_4(l0[3]),
        .rd_data_5(l0[4]), .rd_data_6(l0[5]), .rd_data_7(l0[6]), .rd_data_8(l0[7])
    );

    // g runs 0..2047: first half is the mu stream, second half the var stream.
    function automatic logic [15:0] word_val(input int pat, input int g);
        int w;
        bit v;
        w = g % 1024;
        v = (g >= 1024);
        case (pat)
            1:       return v ? 16'(32'h5000 + w) : 16'(32'h3000 + w);
            2: begin
                if (!v && w == 63) return 16'hBEEF;
                if (!v && w == 64) return 16'hDEAD;
                return 16'(32'h1000 + w);
            end
            default: return v ? 16'(32'h2000 + w) : 16'(32'h1000 + w);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_read(input logic sel, input logic [2:0] col);
        rd_en  = 1'b1;
        rd_sel = sel;
        rd_col = col;
        step();
        rd_en  = 1'b0;
    endtask

    task automatic stream(input int pat, input bit gaps, input int stop_at, input int start_at,
                          output int hs, output int rdy_cycles, output bit early);
        int  cyc;
        bit  r, hs_now, started;
        hs = 0; cyc = 0; rdy_cycles = 0; early = 0; started = 0;
        while (hs < stop_at && cyc < 20000) begin
            if (done64) early = 1;
            wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_data  = word_val(pat, hs);
            start    = (hs == start_at && !started);
            if (start) started = 1;
            r = ready64;
            if (r) rdy_cycles++;
            hs_now = wr_valid && r;
            step();
            if (hs_now) hs++;
            cyc++;
        end
        wr_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; wr_valid = 0; wr_data = 0; rd_en = 0; rd_sel = 0; rd_col = 0;
        step(); step();
        rst = 1'b0;
        checks++;
        if (ready64 !== 1'b0 || done64 !== 1'b0 || valid64 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: ready=%b done=%b valid=%b, required 0 0 0", ready64, done64, valid64);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (l64[k] !== 16'h0) begin
                failures++;
                $display("[TB] FAIL reset_lane%0d: got %h, required 0000", k + 1, l64[k]);
            end
        end
        do_read(1'b0, 3'd2);
        checks++;
        if (valid64 !== 1'b0 || l64[0] !== 16'h0 || l64[7] !== 16'h0) begin
            failures++;
            $display("[TB] FAIL read_in_idle: valid=%b lane1=%h lane8=%h, required 0 0000 0000", valid64, l64[0], l64[7]);
        end
    endtask

    task automatic test_full_load();
        int hs, rc;
        bit early;
        pulse_start();
        stream(0, 1'b0, 2048, -1, hs, rc, early);
        checks++;
        if (rc !== 2048 || hs !== 2048) begin
            failures++;
            $display("[TB] FAIL full_ready_cycles: ready cycles=%0d handshakes=%0d, required 2048 2048", rc, hs);
        end
        checks++;
        if (done64 !== 1'b1 || early !== 1'b0 || ready64 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_done: done=%b early=%b ready=%b, required 1 0 0", done64, early, ready64);
        end
        do_read(1'b0, 3'd3);
        checks++;
        if (valid64 !== 1'b1 || l64[0] !== 16'h1043 || l64[7] !== 16'h107B) begin
            failures++;
            $display("[TB] FAIL full_mu_col3: valid=%b lane1=%h lane8=%h, required 1 1043 107b", valid64, l64[0], l64[7]);
        end
        step();
        checks++;
        if (valid64 !== 1'b0 || l64[0] !== 16'h1043) begin
            failures++;
            $display("[TB] FAIL hold_no_rd_en: valid=%b lane1=%h, required 0 1043", valid64, l64[0]);
        end
        do_read(1'b1, 3'd0);
        checks++;
        if (valid64 !== 1'b1 || l64[0] !== 16'h2040 || l64[4] !== 16'h2060) begin
            failures++;
            $display("[TB] FAIL full_var_col0: valid=%b lane1=%h lane5=%h, required 1 2040 2060", valid64, l64[0], l64[4]);
        end
    endtask

    task automatic test_window_edges();
        int hs, rc;
        bit early;
        logic [15:0] exp;
        pulse_start();
        stream(2, 1'b0, 2048, -1, hs, rc, early);
        for (int c = 0; c < 8; c++) begin
            do_read(1'b0, 3'(c));
            for (int k = 0; k < 8; k++) begin
                exp = (k * 8 + c == 63) ? 16'hBEEF : 16'(32'h1000 + k * 8 + c);
                checks++;
                if (l0[k] !== exp || l0[k] === 16'hDEAD) begin
                    failures++;
                    $display("[TB] FAIL edge_base0 col%0d lane%0d: got %h, required %h", c, k + 1, l0[k], exp);
                end
            end
            if (c == 0) begin
                checks++;
                if (l64[0] !== 16'hDEAD) begin
                    failures++;
                    $display("[TB] FAIL edge_base64_first: got %h, required dead", l64[0]);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        int hs, rc;
        bit early;
        logic [15:0] exp;
        pulse_start();
        stream(0, 1'b1, 2048, 1500, hs, rc, early);
        checks++;
        if (hs !== 2048 || done64 !== 1'b1 || early !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_done: handshakes=%0d done=%b early=%b, required 2048 1 0", hs, done64, early);
        end
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 8; c++) begin
                do_read(1'(s), 3'(c));
                for (int k = 0; k < 8; k++) begin
                    exp = 16'((s ? 32'h2000 : 32'h1000) + 64 + k * 8 + c);
                    checks++;
                    if (l64[k] !== exp) begin
                        failures++;
                        $display("[TB] FAIL bp_bank sel%0d col%0d lane%0d: got %h, required %h", s, c, k + 1, l64[k], exp);
                    end
                end
            end
        end
    endtask

    task automatic test_reload();
        int hs, rc;
        bit early;
        start = 1'b1; rd_en = 1'b1; rd_sel = 1'b0; rd_col = 3'd3;
        step();
        start = 1'b0; rd_en = 1'b0;
        checks++;
        if (valid64 !== 1'b1 || l64[0] !== 16'h1043 || done64 !== 1'b0 || ready64 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reload_start_read: valid=%b lane1=%h done=%b ready=%b, required 1 1043 0 1",
                     valid64, l64[0], done64, ready64);
        end
        do_read(1'b0, 3'd3);
        checks++;
        if (valid64 !== 1'b0 || l64[0] !== 16'h0 || l64[7] !== 16'h0) begin
            failures++;
            $display("[TB] FAIL read_while_loading: valid=%b lane1=%h lane8=%h, required 0 0000 0000", valid64, l64[0], l64[7]);
        end
        stream(1, 1'b0, 2048, -1, hs, rc, early);
        checks++;
        if (hs !== 2048 || done64 !== 1'b1 || early !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reload_done: handshakes=%0d done=%b early=%b, required 2048 1 0", hs, done64, early);
        end
        do_read(1'b0, 3'd3);
        checks++;
        if (l64[0] !== 16'h3043 || l64[7] !== 16'h307B) begin
            failures++;
            $display("[TB] FAIL reload_mu: lane1=%h lane8=%h, required 3043 307b", l64[0], l64[7]);
        end
        do_read(1'b1, 3'd0);
        checks++;
        if (l64[0] !== 16'h5040) begin
            failures++;
            $display("[TB] FAIL reload_var: lane1=%h, required 5040", l64[0]);
        end
    endtask

    task automatic test_reset_mid_load();
        int hs, rc;
        bit early;
        pulse_start();
        stream(0, 1'b0, 500, -1, hs, rc, early);
        rst = 1'b1; wr_valid = 1'b1; wr_data = word_val(0, 500);
        step();
        rst = 1'b0; wr_valid = 1'b0;
        checks++;
        if (ready64 !== 1'b0 || done64 !== 1'b0 || valid64 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midload_reset: ready=%b done=%b valid=%b, required 0 0 0", ready64, done64, valid64);
        end
        do_read(1'b0, 3'd3);
        checks++;
        if (valid64 !== 1'b0 || l64[0] !== 16'h0 || l64[7] !== 16'h0) begin
            failures++;
            $display("[TB] FAIL midload_read: valid=%b lane1=%h lane8=%h, required 0 0000 0000", valid64, l64[0], l64[7]);
        end
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        checks++;
        if (ready64 !== 1'b0 || done64 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_no_accept: ready=%b done=%b, required 0 0", ready64, done64);
        end
        pulse_start();
        stream(0, 1'b0, 2048, -1, hs, rc, early);
        checks++;
        if (hs !== 2048 || done64 !== 1'b1 || early !== 1'b0) begin
            failures++;
            $display("[TB] FAIL after_reset_load: handshakes=%0d done=%b early=%b, required 2048 1 0", hs, done64, early);
        end
        do_read(1'b0, 3'd3);
        checks++;
        if (valid64 !== 1'b1 || l64[0] !== 16'h1043) begin
            failures++;
            $display("[TB] FAIL after_reset_read: valid=%b lane1=%h, required 1 1043", valid64, l64[0]);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_window_edges();
        test_back_pressure();
        test_reload();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
